// File: rtl/fft_if.sv
// Toggle flip-flop port bundle: toggle enable in, state bit and complement out.
interface fft_if;
    logic t;
    logic q;
    logic q_n;

    // Controller side drives the toggle enable and observes the state.
    modport master (
        output t,
        input  q,
        input  q_n
    );

    // Flip-flop side samples the toggle enable and presents the state.
    modport slave (
        input  t,
        output q,
        output q_n
    );
endinterface

// File: rtl/fft.sv
// Toggle flip-flop: divide-by-2 primitive for the divider chain.
// q inverts on every rising edge with t high, holds otherwise;
// synchronous reset loads RESET_VAL and takes priority over toggling.
module fft #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic  clk,
    input  logic  rst,
    fft_if.slave  bus
);

    logic q_reg;
    logic q_next;

    // Next-state: toggle when enabled, otherwise hold.
    always_comb begin
        q_next = q_reg;
        if (bus.t) begin
            q_next = ~q_reg;
        end
    end

    // State register; reset wins over a simultaneous toggle.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg <= RESET_VAL;
        end else begin
            q_reg <= q_next;
        end
    end

    // Complement is derived from the single state bit so it can never disagree with q.
    assign bus.q   = q_reg;
    assign bus.q_n = ~q_reg;

endmodule

// File: tb/tb_fft.sv
// Directed bench for fft: two instances (RESET_VAL 0 and 1) driven in lockstep.
module tb_fft;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    logic e0;
    logic e1;
    logic pre0;
    logic pre1;
    logic last0;
    int   toggles;

    fft_if bus0 ();
    fft_if bus1 ();

    fft #(.RESET_VAL(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    fft #(.RESET_VAL(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    // Apply rst/t, take one rising edge, update the reference bits, check both DUTs.
    task automatic tick(input string tag, input logic r, input logic tt);
        rst     = r;
        bus0.t  = tt;
        bus1.t  = tt;
        @(posedge clk);
        if (r) begin
            e0 = 1'b0;
            e1 = 1'b1;
        end else if (tt) begin
            e0 = ~e0;
            e1 = ~e1;
        end
        #1;
        chk({tag, ".q0"},   bus0.q,   e0);
        chk({tag, ".qn0"},  bus0.q_n, ~e0);
        chk({tag, ".q1"},   bus1.q,   e1);
        chk({tag, ".qn1"},  bus1.q_n, ~e1);
        $display("t=%0t %s rst=%b t=%b q0=%b q_n0=%b q1=%b q_n1=%b",
                 $time, tag, r, tt, bus0.q, bus0.q_n, bus1.q, bus1.q_n);
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        e0     = 1'b0;
        e1     = 1'b1;
        rst    = 1'b1;
        bus0.t = 1'b0;
        bus1.t = 1'b0;
        #5;

        // Reset: two edges, t low then t high; no toggle allowed.
        tick("reset_t0", 1'b1, 1'b0);
        tick("reset_t1", 1'b1, 1'b1);
        chk("reset_val0", bus0.q, 1'b0);
        chk("reset_val1", bus1.q, 1'b1);

        // Hold from reset value for 25 cycles.
        for (int i = 0; i < 25; i++) tick("hold_a", 1'b0, 1'b0);
        chk("hold_a_end0", bus0.q, 1'b0);

        // Divide-by-2 for 25 cycles: odd count leaves q0 at 1, q1 at 0.
        for (int i = 0; i < 25; i++) tick("div2", 1'b0, 1'b1);
        chk("div2_end0", bus0.q, 1'b1);
        chk("div2_end1", bus1.q, 1'b0);

        // Hold after toggling: frozen for 25 cycles.
        for (int i = 0; i < 25; i++) tick("hold_b", 1'b0, 1'b0);
        chk("hold_b_end0", bus0.q, 1'b1);

        // A reset pulse entirely between edges must have no effect.
        rst = 1'b1;
        #5;
        rst = 1'b0;
        tick("rst_glitch", 1'b0, 1'b0);
        chk("rst_glitch_q0", bus0.q, 1'b1);

        // Continuous toggle across two back-to-back windows: count every change.
        pre0    = bus0.q;
        pre1    = bus1.q;
        last0   = bus0.q;
        toggles = 0;
        for (int i = 0; i < 50; i++) begin
            tick("cont", 1'b0, 1'b1);
            if (bus0.q !== last0) toggles++;
            last0 = bus0.q;
        end
        total++;
        assert (toggles == 50) else begin
            bad++;
            $error("FAIL cont_toggles observed=%0d expected=%0d", toggles, 50);
        end
        chk("cont_final0", bus0.q, pre0);
        chk("cont_final1", bus1.q, pre1);
        chk("cont_abs0", bus0.q, 1'b1);

        // Reset priority while toggling with q0 = 1.
        tick("prio_tog", 1'b0, 1'b1);
        chk("prio_pre0", bus0.q, 1'b0);
        tick("prio_tog2", 1'b0, 1'b1);
        chk("prio_pre0b", bus0.q, 1'b1);
        tick("prio_rst", 1'b1, 1'b1);
        chk("prio_rst0", bus0.q, 1'b0);
        chk("prio_rst1", bus1.q, 1'b1);
        tick("prio_after", 1'b0, 1'b1);
        chk("prio_after0", bus0.q, 1'b1);
        chk("prio_after1", bus1.q, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
